prbs_checker: RTL and testbench



---
 rtl/prbs_checker.sv | 210 +++++++++++++++++++++
 tb/tb_prbs_checker.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
//
// Serial PRBS receiver/checker. A Fibonacci LFSR self-synchronises to the
// incoming bit stream (SEED), proves the alignment over a run of correct
// predictions (VERIFY) and then free-runs as a flywheel (LOCKED). While
// locked it counts checked bits and bit errors. A burst of consecutive
// errors drops lock and restarts synchronisation.
//
// Optional build macro: PRBS_CHK_LEDS_EN adds the leds[3:0] status port
// (locked, error stretch, lock-lost toggle, heartbeat). Without it the port
// and its stretch/heartbeat logic are absent.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   din        in   received serial bit
//   din_valid  in   din is sampled only when high
//   clr_cnt    in   synchronous clear of err_cnt and bit_cnt
//   locked     out  high while locked
//   err_pulse  out  one-cycle pulse per mismatched bit (VERIFY or LOCKED)
//   lock_lost  out  one-cycle pulse when lock is dropped
//   err_cnt    out  saturating error count while locked
//   bit_cnt    out  saturating checked-bit count while locked
//   leds       out  status LEDs (PRBS_CHK_LEDS_EN only)
// -----------------------------------------------------------------------------
module prbs_checker #(
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] TAPS         = 16'hD008,
    parameter int                LOCK_MATCHES = 32,
    parameter int                LOSS_ERRS    = 8,
    parameter int                CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic             lock_lost,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
`ifdef PRBS_CHK_LEDS_EN
    ,
    output logic [3:0]       leds
`endif
);

    localparam int FILL_W  = $clog2(LFSR_W + 1);
    localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
    localparam int RUN_W   = $clog2(LOSS_ERRS + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(LFSR_W - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_MATCHES - 1);
    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(LOSS_ERRS - 1);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q;
    logic [LFSR_W-1:0]  sr_q;
    logic [FILL_W-1:0]  fill_q;
    logic [MATCH_W-1:0] match_q;
    logic [RUN_W-1:0]   err_run_q;
    logic               locked_q;
    logic               err_pulse_q;
    logic               lock_lost_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic [CNT_W-1:0]   bit_cnt_q;

    logic pred;
    logic mismatch;
    logic sr_zero;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign pred     = ^(sr_q & TAPS);
    assign mismatch = din ^ pred;
    // An all-zero register predicts zero forever; a stuck-at-0 line would
    // otherwise look like a perfect match.
    assign sr_zero  = (sr_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEED;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            err_run_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            lock_lost_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            lock_lost_q <= 1'b0;

            // Clear wins over any same-cycle increment below.
            if (clr_cnt) begin
                err_cnt_q <= '0;
                bit_cnt_q <= '0;
            end

            if (din_valid) begin
                unique case (state_q)
                    SEED: begin
                        sr_q <= {sr_q[LFSR_W-2:0], din};
                        if (fill_q == FILL_LAST) begin
                            state_q <= VERIFY;
                            fill_q  <= '0;
                            match_q <= '0;
                        end else begin
                            fill_q <= fill_q + 1'b1;
                        end
                    end

                    VERIFY: begin
                        sr_q <= {sr_q[LFSR_W-2:0], din};
                        if (mismatch || sr_zero) begin
                            err_pulse_q <= 1'b1;
                            state_q     <= SEED;
                            fill_q      <= '0;
                        end else if (match_q == MATCH_LAST) begin
                            state_q   <= LOCKED;
                            locked_q  <= 1'b1;
                            err_run_q <= '0;
                        end else begin
                            match_q <= match_q + 1'b1;
                        end
                    end

                    LOCKED: begin
                        // Flywheel: feed back the prediction so a corrupted
                        // bit never enters the register.
                        sr_q <= {sr_q[LFSR_W-2:0], pred};
                        if (!clr_cnt) begin
                            bit_cnt_q <= sat_inc(bit_cnt_q);
                        end
                        if (mismatch) begin
                            err_pulse_q <= 1'b1;
                            if (!clr_cnt) begin
                                err_cnt_q <= sat_inc(err_cnt_q);
                            end
                            if (err_run_q == RUN_LAST) begin
                                lock_lost_q <= 1'b1;
                                locked_q    <= 1'b0;
                                state_q     <= SEED;
                                fill_q      <= '0;
                                err_run_q   <= '0;
                            end else begin
                                err_run_q <= err_run_q + 1'b1;
                            end
                        end else begin
                            err_run_q <= '0;
                        end
                    end

                    default: begin
                        state_q  <= SEED;
                        fill_q   <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign lock_lost = lock_lost_q;
    assign err_cnt   = err_cnt_q;
    assign bit_cnt   = bit_cnt_q;

`ifdef PRBS_CHK_LEDS_EN
    logic [21:0] stretch_q;
    logic [25:0] heart_q;
    logic        toggle_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stretch_q <= '0;
            heart_q   <= '0;
            toggle_q  <= 1'b0;
        end else begin
            heart_q <= heart_q + 1'b1;
            // Reload on every error so the LED stays lit 2^22 cycles past
            // the most recent one (pulse cycle plus 2^22-1 countdown).
            if (err_pulse_q) begin
                stretch_q <= '1;
            end else if (stretch_q != '0) begin
                stretch_q <= stretch_q - 1'b1;
            end
            if (lock_lost_q) begin
                toggle_q <= ~toggle_q;
            end
        end
    end

    assign leds = {heart_q[25], toggle_q, err_pulse_q | (stretch_q != '0), locked_q};
`endif

endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;

    localparam int          LFSR_W       = 16;
    localparam logic [15:0] TAPS         = 16'hD008;
    localparam int          LOCK_MATCHES = 32;
    localparam int          LOSS_ERRS    = 8;
    // Narrow counters so saturation is reachable in a short run.
    localparam int          CNT_W        = 11;
    localparam longint      CMAX         = (longint'(1) << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             din = 1'b0;
    logic             din_valid = 1'b0;
    logic             clr_cnt = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic             lock_lost;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] bit_cnt;
`ifdef PRBS_CHK_LEDS_EN
    logic [3:0]       leds;
`endif

    always #5 clk = ~clk;

    prbs_checker #(
        .LFSR_W(LFSR_W), .TAPS(TAPS), .LOCK_MATCHES(LOCK_MATCHES),
        .LOSS_ERRS(LOSS_ERRS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .lock_lost(lock_lost),
        .err_cnt(err_cnt), .bit_cnt(bit_cnt)
`ifdef PRBS_CHK_LEDS_EN
        , .leds(leds)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // History of the last LFSR_W bits that entered the checker's register,
    // oldest first; m_hist[LFSR_W-1-i] is register bit i.
    bit     m_on = 1'b0;
    int     m_mode;            // 0 = seeding, 1 = verifying, 2 = locked
    bit     m_hist[$];
    int     m_nseed, m_nmatch, m_run;
    longint m_ecnt, m_bcnt;
    bit     e_locked, e_pulse, e_lost;

    function automatic bit m_pred();
        bit p = 1'b0;
        for (int i = 0; i < LFSR_W; i++)
            if (TAPS[i]) p ^= m_hist[LFSR_W-1-i];
        return p;
    endfunction

    function automatic bit m_allzero();
        foreach (m_hist[i]) if (m_hist[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_push(input bit b);
        m_hist.push_back(b);
        void'(m_hist.pop_front());
    endtask

    function automatic longint m_sat(input longint v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_step(input bit r, input bit v, input bit d, input bit c);
        bit p, bad;
        e_pulse = 1'b0;
        e_lost  = 1'b0;
        if (r) begin
            m_on = 1'b1;
            m_mode = 0;
            m_hist.delete();
            for (int i = 0; i < LFSR_W; i++) m_hist.push_back(1'b0);
            m_nseed = 0; m_nmatch = 0; m_run = 0;
            m_ecnt = 0; m_bcnt = 0;
            e_locked = 1'b0;
            return;
        end
        if (c) begin
            m_ecnt = 0;
            m_bcnt = 0;
        end
        if (v) begin
            p = m_pred();
            case (m_mode)
                0: begin
                    m_push(d);
                    m_nseed++;
                    if (m_nseed == LFSR_W) begin m_mode = 1; m_nmatch = 0; end
                end
                1: begin
                    bad = (d != p) || m_allzero();
                    m_push(d);
                    if (bad) begin
                        e_pulse = 1'b1; m_mode = 0; m_nseed = 0;
                    end else begin
                        m_nmatch++;
                        if (m_nmatch == LOCK_MATCHES) begin m_mode = 2; m_run = 0; end
                    end
                end
                default: begin
                    m_push(p);
                    if (!c) m_bcnt = m_sat(m_bcnt);
                    if (d != p) begin
                        e_pulse = 1'b1;
                        if (!c) m_ecnt = m_sat(m_ecnt);
                        m_run++;
                        if (m_run == LOSS_ERRS) begin
                            e_lost = 1'b1; m_mode = 0; m_nseed = 0; m_run = 0;
                        end
                    end else begin
                        m_run = 0;
                    end
                end
            endcase
        end
        e_locked = (m_mode == 2);
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_on) begin
            check("locked",    locked,    e_locked);
            check("err_pulse", err_pulse, e_pulse);
            check("lock_lost", lock_lost, e_lost);
            check("err_cnt",   err_cnt,   m_ecnt);
            check("bit_cnt",   bit_cnt,   m_bcnt);
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] g;            // transmitter LFSR state
    int          pulses = 0;
    bit          any_lock = 1'b0;

    task automatic step(input bit r, input bit v, input bit d, input bit c);
        @(negedge clk);
        rst = r; din_valid = v; din = d; clr_cnt = c;
        @(posedge clk);
        model_step(r, v, d, c);
        #1;
        if (err_pulse === 1'b1) pulses++;
        if (locked === 1'b1) any_lock = 1'b1;
    endtask

    // One valid bit of the correct stream, optionally inverted on the wire.
    task automatic send(input bit flip, input bit c);
        bit b;
        b = ^(g & TAPS);
        g = {g[14:0], b};
        step(1'b0, 1'b1, b ^ flip, c);
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_locked",  locked,    0);
        check("rst_pulse",   err_pulse, 0);
        check("rst_err_cnt", err_cnt,   0);
        check("rst_bit_cnt", bit_cnt,   0);

        // Acquire lock from seed ACE1
        g = 16'hACE1;
        pulses = 0;
        send_n(47);
        check("lock_not_before_48", locked, 0);
        send(1'b0, 1'b0);
        check("lock_after_48", locked, 1);
        check("no_pulse_acquire", pulses, 0);
        check("err_cnt_acquire", err_cnt, 0);
        check("model_pin_locked", e_locked, 1);

        // Single error after 1000 good bits
        send_n(1000);
        pulses = 0;
        send(1'b1, 1'b0);
        check("single_err_pulse", err_pulse, 1);
        check("single_err_cnt", err_cnt, 1);
        check("single_bit_cnt", bit_cnt, 1001);
        check("single_still_locked", locked, 1);
        send_n(100);
        check("single_pulse_count", pulses, 1);
        check("single_err_cnt_after", err_cnt, 1);
        check("model_pin_bcnt", m_bcnt, 1101);

        // Burst of 8 errors drops lock
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_err_cnt", err_cnt, 0);
        check("clr_bit_cnt", bit_cnt, 0);
        for (int i = 0; i < 7; i++) send(1'b1, 1'b0);
        check("burst7_locked", locked, 1);
        check("burst7_lost", lock_lost, 0);
        send(1'b1, 1'b0);
        check("burst8_lost", lock_lost, 1);
        check("burst8_unlocked", locked, 0);
        check("burst8_err_cnt", err_cnt, 8);
        check("burst8_bit_cnt", bit_cnt, 8);
        send_n(47);
        check("relock_not_yet", locked, 0);
        send(1'b0, 1'b0);
        check("relock_48", locked, 1);
        check("relock_err_cnt", err_cnt, 8);

        // Stuck-at-0 line
        step(1'b1, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        any_lock = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 17) check("stuck_pulse_bit17", err_pulse, 1);
        end
        check("stuck_pulse_count", pulses, 11);
        check("stuck_never_locked", any_lock, 0);

        // Valid one cycle in three
        step(1'b1, 1'b0, 1'b0, 1'b0);
        g = 16'hACE1;
        for (int i = 1; i <= 48; i++) begin
            send(1'b0, 1'b0);
            if (i == 47) check("sparse_not_locked_47", locked, 0);
            if (i == 48) check("sparse_locked_48", locked, 1);
            idle(2);
        end
        for (int i = 0; i < 10; i++) begin send(1'b0, 1'b0); idle(2); end
        check("sparse_bit_cnt", bit_cnt, 10);
        send(1'b1, 1'b0);
        check("sparse_err_cnt", err_cnt, 1);
        idle(2);
        send(1'b1, 1'b1);
        check("clr_vs_err_pulse", err_pulse, 1);
        check("clr_vs_err_cnt", err_cnt, 0);
        check("clr_vs_bit_cnt", bit_cnt, 0);
        idle(2);
        check("idle_bit_cnt", bit_cnt, 0);

        // Reset while locked with err_cnt = 5
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b0);
            send_n(3);
        end
        check("pre_rst_err_cnt", err_cnt, 5);
        check("pre_rst_locked", locked, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("midrst_locked", locked, 0);
        check("midrst_err_cnt", err_cnt, 0);
        check("midrst_bit_cnt", bit_cnt, 0);
`ifdef PRBS_CHK_LEDS_EN
        check("midrst_leds", leds, 0);
`endif

        // Counter saturation
        g = 16'hACE1;
        send_n(48);
        check("sat_locked", locked, 1);
        send_n(2100);
        check("bit_cnt_saturated", bit_cnt, CMAX);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_clear", bit_cnt, 0);
        send(1'b0, 1'b0);
        check("after_sat_clear", bit_cnt, 1);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
